cgra_cfg_sequencer: RTL

//  Synthesizable config-bus master for the CGRA Interconnect. Executes a stream of commands: config write,

---
 rtl/cgra_cfg_sequencer.sv | 283 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/cgra_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cgra_cfg_sequencer
// Brief    : Config-bus master for the CGRA interconnect. Executes a command
//            stream (config write, readback-verify, readback-capture, stall
//            control, flush pulse) with optional repeat and address
//            auto-increment, replacing bench-driven bitstream load, SRAM
//            prefill and SRAM readback.
// Options  : CFG_SEQ_HALT_ON_ERR_EN - when defined, the first readback
//            mismatch sets a sticky halt (command abandoned, cmd_ready low,
//            busy high until reset). Undefined: mismatches are only counted.
// Revision : 1.0 - initial release
// ============================================================================
module cgra_cfg_sequencer #(
  parameter int                    ADDR_W         = 32,
  parameter int                    DATA_W         = 32,
  parameter int                    NUM_STALL      = 4,
  parameter int                    READ_LAT       = 5,
  parameter int                    FLUSH_HOLD     = 2,
  parameter logic [DATA_W-1:0]     FLUSH_CLR_MASK = DATA_W'(32'h0000_FFFF),
  parameter int                    INC_LSB        = 24,
  parameter logic [NUM_STALL-1:0]  STALL_RST      = {NUM_STALL{1'b1}}
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_op,
  input  logic [ADDR_W-1:0]    cmd_addr,
  input  logic [DATA_W-1:0]    cmd_data,
  input  logic [15:0]          cmd_rpt,
  output logic [ADDR_W-1:0]    config_addr,
  output logic [DATA_W-1:0]    config_data,
  output logic                 config_read,
  output logic                 config_write,
  input  logic [DATA_W-1:0]    read_config_data,
  output logic [NUM_STALL-1:0] stall,
  output logic                 rd_valid,
  output logic [DATA_W-1:0]    rd_data,
  output logic                 mm_valid,
  output logic [ADDR_W-1:0]    mm_addr,
  output logic [DATA_W-1:0]    mm_rdata,
  output logic [15:0]          err_cnt,
  output logic                 busy
);

  localparam int CNT_W = 16;

  localparam logic [2:0] OP_WRITE      = 3'd1;
  localparam logic [2:0] OP_RD_CHECK   = 3'd2;
  localparam logic [2:0] OP_RD_CAPTURE = 3'd3;
  localparam logic [2:0] OP_STALL      = 3'd4;
  localparam logic [2:0] OP_FLUSH      = 3'd5;

  // Per-repeat address step: one unit of the SRAM word-index field.
  localparam logic [ADDR_W-1:0] ADDR_INC = ADDR_W'(1) << INC_LSB;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR    = 3'd1,
    S_RD    = 3'd2,
    S_FL_HI = 3'd3,
    S_FL_LO = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic                  is_check_q, is_check_d;
  logic [DATA_W-1:0]     exp_q, exp_d;
  logic [15:0]           rem_q, rem_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  halt_q, halt_d;

  logic                  cmd_ready_q, cmd_ready_d;
  logic [ADDR_W-1:0]     config_addr_q, config_addr_d;
  logic [DATA_W-1:0]     config_data_q, config_data_d;
  logic                  config_read_q, config_read_d;
  logic                  config_write_q, config_write_d;
  logic [NUM_STALL-1:0]  stall_q, stall_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]     rd_data_q, rd_data_d;
  logic                  mm_valid_q, mm_valid_d;
  logic [ADDR_W-1:0]     mm_addr_q, mm_addr_d;
  logic [DATA_W-1:0]     mm_rdata_q, mm_rdata_d;
  logic [15:0]           err_cnt_q, err_cnt_d;
  logic                  busy_q, busy_d;

  logic                  accept;
  logic                  mismatch;

  assign accept   = cmd_valid & cmd_ready_q;
  assign mismatch = (read_config_data != exp_q);

  // Next-state and next-output computation for the command sequencer.
  always_comb begin
    state_d        = state_q;
    is_check_d     = is_check_q;
    exp_d          = exp_q;
    rem_d          = rem_q;
    cnt_d          = cnt_q;
    halt_d         = halt_q;
    config_addr_d  = config_addr_q;
    config_data_d  = config_data_q;
    config_read_d  = config_read_q;
    config_write_d = config_write_q;
    stall_d        = stall_q;
    rd_valid_d     = 1'b0;
    rd_data_d      = rd_data_q;
    mm_valid_d     = 1'b0;
    mm_addr_d      = mm_addr_q;
    mm_rdata_d     = mm_rdata_q;
    err_cnt_d      = err_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          config_addr_d = cmd_addr;
          exp_d         = cmd_data;
          rem_d         = cmd_rpt;
          cnt_d         = '0;
          is_check_d    = (cmd_op == OP_RD_CHECK);
          case (cmd_op)
            OP_WRITE: begin
              state_d        = S_WR;
              config_write_d = 1'b1;
              config_data_d  = cmd_data;
            end
            OP_RD_CHECK, OP_RD_CAPTURE: begin
              state_d       = S_RD;
              config_read_d = 1'b1;
            end
            OP_STALL: begin
              stall_d = cmd_data[NUM_STALL-1:0];
            end
            OP_FLUSH: begin
              state_d        = S_FL_HI;
              config_write_d = 1'b1;
              config_data_d  = cmd_data;
            end
            default: ;  // NOP and undefined ops: accepted, no bus activity
          endcase
        end
      end

      S_WR: begin
        if (rem_q == 16'd0) begin
          state_d        = S_IDLE;
          config_write_d = 1'b0;
        end else begin
          config_addr_d = config_addr_q + ADDR_INC;
          rem_d         = rem_q - 16'd1;
        end
      end

      S_RD: begin
        if (config_read_q) begin
          if (cnt_q == CNT_W'(READ_LAT - 1)) begin
            // Last cycle of the read window: sample and drop the strobe.
            config_read_d = 1'b0;
            cnt_d         = '0;
            if (is_check_q) begin
              if (mismatch) begin
                mm_valid_d = 1'b1;
                mm_addr_d  = config_addr_q;
                mm_rdata_d = read_config_data;
                if (err_cnt_q != 16'hFFFF) begin
                  err_cnt_d = err_cnt_q + 16'd1;
                end
`ifdef CFG_SEQ_HALT_ON_ERR_EN
                halt_d = 1'b1;
`endif
              end
            end else begin
              rd_valid_d = 1'b1;
              rd_data_d  = read_config_data;
            end
            if (rem_q == 16'd0) begin
              state_d = S_IDLE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          // One-cycle gap between transactions; step to the next word.
          config_read_d = 1'b1;
          config_addr_d = config_addr_q + ADDR_INC;
          rem_d         = rem_q - 16'd1;
        end
      end

      S_FL_HI: begin
        if (cnt_q == CNT_W'(FLUSH_HOLD - 1)) begin
          state_d       = S_FL_LO;
          cnt_d         = '0;
          config_data_d = config_data_q & ~FLUSH_CLR_MASK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_FL_LO: begin
        state_d        = S_IDLE;
        config_write_d = 1'b0;
      end

      default: begin
        state_d        = S_IDLE;
        config_write_d = 1'b0;
        config_read_d  = 1'b0;
      end
    endcase

    // A halt abandons the rest of the command and parks the sequencer.
    if (halt_d) begin
      state_d        = S_IDLE;
      config_read_d  = 1'b0;
      config_write_d = 1'b0;
    end

    cmd_ready_d = (state_d == S_IDLE) & ~halt_d;
    busy_d      = (state_d != S_IDLE) | halt_d;
  end

  // State and registered outputs; reset abandons any in-flight command.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      is_check_q     <= 1'b0;
      exp_q          <= '0;
      rem_q          <= '0;
      cnt_q          <= '0;
      halt_q         <= 1'b0;
      cmd_ready_q    <= 1'b0;
      config_addr_q  <= '0;
      config_data_q  <= '0;
      config_read_q  <= 1'b0;
      config_write_q <= 1'b0;
      stall_q        <= STALL_RST;
      rd_valid_q     <= 1'b0;
      rd_data_q      <= '0;
      mm_valid_q     <= 1'b0;
      mm_addr_q      <= '0;
      mm_rdata_q     <= '0;
      err_cnt_q      <= '0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      is_check_q     <= is_check_d;
      exp_q          <= exp_d;
      rem_q          <= rem_d;
      cnt_q          <= cnt_d;
      halt_q         <= halt_d;
      cmd_ready_q    <= cmd_ready_d;
      config_addr_q  <= config_addr_d;
      config_data_q  <= config_data_d;
      config_read_q  <= config_read_d;
      config_write_q <= config_write_d;
      stall_q        <= stall_d;
      rd_valid_q     <= rd_valid_d;
      rd_data_q      <= rd_data_d;
      mm_valid_q     <= mm_valid_d;
      mm_addr_q      <= mm_addr_d;
      mm_rdata_q     <= mm_rdata_d;
      err_cnt_q      <= err_cnt_d;
      busy_q         <= busy_d;
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign config_addr  = config_addr_q;
  assign config_data  = config_data_q;
  assign config_read  = config_read_q;
  assign config_write = config_write_q;
  assign stall        = stall_q;
  assign rd_valid     = rd_valid_q;
  assign rd_data      = rd_data_q;
  assign mm_valid     = mm_valid_q;
  assign mm_addr      = mm_addr_q;
  assign mm_rdata     = mm_rdata_q;
  assign err_cnt      = err_cnt_q;
  assign busy         = busy_q;

endmodule
`default_nettype wire
